// File: rtl/vga_scan_timing_if.sv
// Raster timing bundle: pixel tick, coordinates, line/frame markers and the
// pipeline-aligned blank/sync strobes.
interface vga_scan_timing_if;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       line_start;
    logic       frame_start;
    logic       blank;
    logic       hsync;
    logic       vsync;

    modport master (
        output pix_en, hcount, vcount, line_start, frame_start, blank, hsync, vsync
    );

    modport slave (
        input pix_en, hcount, vcount, line_start, frame_start, blank, hsync, vsync
    );
endinterface

// File: rtl/vga_scan_timing.sv
// Raster timing generator: pixel-clock enable, pixel coordinates, and
// blank/hsync/vsync delayed PIPE pixel ticks to line up with the colour pipeline.
module vga_scan_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE     = 2
) (
    input  logic               clk,
    input  logic               resetn,
    vga_scan_timing_if.master  scan
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [9:0]       hcount_reg;
    logic [9:0]       vcount_reg;
    logic             pix_en;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;
    logic [2:0]       raw_flags;
    logic [2:0]       out_flags;

    assign pix_en = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt_reg <= '0;
            hcount_reg  <= '0;
            vcount_reg  <= '0;
        end else begin
            div_cnt_reg <= pix_en ? '0 : div_cnt_reg + 1'b1;
            if (pix_en) begin
                // Vertical wrap shares the edge on which the line wraps.
                if (hcount_reg == H_LAST) begin
                    hcount_reg <= '0;
                    vcount_reg <= (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
                end else begin
                    hcount_reg <= hcount_reg + 1'b1;
                end
            end
        end
    end

    assign active    = (hcount_reg < H_ACT) && (vcount_reg < V_ACT);
    assign hs_raw    = !((hcount_reg >= HS_START) && (hcount_reg < HS_END));
    assign vs_raw    = !((vcount_reg >= VS_START) && (vcount_reg < VS_END));
    assign raw_flags = {~active, hs_raw, vs_raw};

    generate
        if (PIPE == 0) begin : g_no_delay
            assign out_flags = raw_flags;
        end else begin : g_delay
            // Stages reset to "blanked, syncs idle" so start-up never emits a stray pulse.
            logic [2:0] stage_reg [PIPE];

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < PIPE; i++) begin
                        stage_reg[i] <= 3'b111;
                    end
                end else if (pix_en) begin
                    stage_reg[0] <= raw_flags;
                    for (int i = 1; i < PIPE; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign out_flags = stage_reg[PIPE-1];
        end
    endgenerate

    assign scan.pix_en      = pix_en;
    assign scan.hcount      = hcount_reg;
    assign scan.vcount      = vcount_reg;
    assign scan.line_start  = pix_en && (hcount_reg == '0);
    assign scan.frame_start = pix_en && (hcount_reg == '0) && (vcount_reg == '0);
    assign scan.blank       = out_flags[2];
    assign scan.hsync       = out_flags[1];
    assign scan.vsync       = out_flags[0];

endmodule
